// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage and its neighbours.
// Opcodes, ALU encodings and the control bundle travel with ID/EX.
package id_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef struct packed {
      logic       regwrite;
      logic       alusrc;
      logic       memtoreg;
      logic       memread;
      logic       memwrite;
      logic       branch;
      logic       jump;
      logic       lui;
      logic       illegal;
      logic [2:0] aluctrl;
   } ctrl_t;

   // Unknown opcodes and R-type functs collapse to a bare illegal flag.
   function automatic ctrl_t decode(input logic [5:0] op,
                                    input logic [5:0] funct);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: begin
            c.regwrite = 1'b1;
            case (funct)
               FN_ADD:  c.aluctrl = ALU_ADD;
               FN_SUB:  c.aluctrl = ALU_SUB;
               FN_AND:  c.aluctrl = ALU_AND;
               FN_OR:   c.aluctrl = ALU_OR;
               FN_SLT:  c.aluctrl = ALU_SLT;
               default: begin
                  c = '0;
                  c.illegal = 1'b1;
               end
            endcase
         end
         OP_LW: begin
            c.alusrc   = 1'b1;
            c.memread  = 1'b1;
            c.memtoreg = 1'b1;
            c.regwrite = 1'b1;
            c.aluctrl  = ALU_ADD;
         end
         OP_SW: begin
            c.alusrc   = 1'b1;
            c.memwrite = 1'b1;
            c.aluctrl  = ALU_ADD;
         end
         OP_BEQ: begin
            c.branch  = 1'b1;
            c.aluctrl = ALU_SUB;
         end
         OP_ADDI: begin
            c.alusrc   = 1'b1;
            c.regwrite = 1'b1;
            c.aluctrl  = ALU_ADD;
         end
         OP_J: begin
            c.jump = 1'b1;
         end
         OP_LUI: begin
            c.lui      = 1'b1;
            c.alusrc   = 1'b1;
            c.regwrite = 1'b1;
         end
         default: begin
            c.illegal = 1'b1;
         end
      endcase
      return c;
   endfunction

   function automatic logic uses_rs(input logic [5:0] op);
      return !(op == OP_J || op == OP_LUI);
   endfunction

   function automatic logic uses_rt(input logic [5:0] op);
      return op == OP_RTYPE || op == OP_SW || op == OP_BEQ;
   endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file: one sync write port, two combinational reads.
// A same-cycle writeback is bypassed onto the read ports.
module id_regfile
   import id_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] i_ra1,
   input  logic [REG_AW-1:0] i_ra2,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_wa,
   input  logic [XLEN-1:0]   i_wd,
   output logic [XLEN-1:0]   o_rd1,
   output logic [XLEN-1:0]   o_rd2
);

   localparam int NREG = 1 << REG_AW;

   logic [XLEN-1:0] r_mem [NREG];
   logic            w_wen;

   assign w_wen = i_we && (i_wa != '0 || ZERO_REG == 0);

   // Storage update; reset clears every register.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wen) begin
         r_mem[i_wa] <= i_wd;
      end
   end

   // Read ports with writeback bypass and hardwired zero register.
   always_comb begin
      o_rd1 = r_mem[i_ra1];
      o_rd2 = r_mem[i_ra2];
      if (i_we && i_wa == i_ra1) o_rd1 = i_wd;
      if (i_we && i_wa == i_ra2) o_rd2 = i_wd;
      if (ZERO_REG != 0 && i_ra1 == '0) o_rd1 = '0;
      if (ZERO_REG != 0 && i_ra2 == '0) o_rd2 = '0;
   end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS-subset decode stage with ID/EX register and load-use stall.
// Handshakes with fetch (if_valid/id_ready) and execute (ex_valid/ex_ready).
module id_stage_pipe
   import id_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [31:0]       if_inst,
   input  logic [XLEN-1:0]   if_pc,
   output logic              id_ready,
   input  logic              flush,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_rd1,
   output logic [XLEN-1:0]   ex_rd2,
   output logic [XLEN-1:0]   ex_imm,
   output logic [25:0]       ex_jtarget,
   output logic [XLEN-1:0]   ex_pc,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_dest,
   output logic              ex_regwrite,
   output logic              ex_alusrc,
   output logic              ex_memtoreg,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic              ex_branch,
   output logic              ex_jump,
   output logic              ex_lui,
   output logic              ex_illegal,
   output logic [2:0]        ex_aluctrl
);

   logic [5:0]        w_op;
   logic [5:0]        w_funct;
   logic [REG_AW-1:0] w_rs;
   logic [REG_AW-1:0] w_rt;
   logic [REG_AW-1:0] w_rd;
   logic [REG_AW-1:0] w_dest;
   logic [XLEN-1:0]   w_imm;
   logic [XLEN-1:0]   w_rd1;
   logic [XLEN-1:0]   w_rd2;
   ctrl_t             w_ctrl;
   logic              w_hazard;

   logic              r_valid;
   ctrl_t             r_ctrl;
   logic [XLEN-1:0]   r_rd1;
   logic [XLEN-1:0]   r_rd2;
   logic [XLEN-1:0]   r_imm;
   logic [25:0]       r_jt;
   logic [XLEN-1:0]   r_pc;
   logic [REG_AW-1:0] r_rs;
   logic [REG_AW-1:0] r_rt;
   logic [REG_AW-1:0] r_dest;

   // Field extraction, control decode and load-use hazard check.
   always_comb begin
      w_op     = if_inst[31:26];
      w_funct  = if_inst[5:0];
      w_rs     = if_inst[21 +: REG_AW];
      w_rt     = if_inst[16 +: REG_AW];
      w_rd     = if_inst[11 +: REG_AW];
      w_imm    = {{(XLEN-16){if_inst[15]}}, if_inst[15:0]};
      w_ctrl   = decode(w_op, w_funct);
      w_dest   = (w_op == OP_RTYPE) ? w_rd : w_rt;
      w_hazard = r_valid && r_ctrl.memread && r_dest != '0 &&
                 ((uses_rs(w_op) && w_rs == r_dest) ||
                  (uses_rt(w_op) && w_rt == r_dest));
   end

   assign id_ready = !rst &&
                     (flush || ((!r_valid || ex_ready) && !w_hazard));

   id_regfile #(
      .XLEN    (XLEN),
      .REG_AW  (REG_AW),
      .ZERO_REG(ZERO_REG)
   ) u_rf (
      .clk  (clk),
      .rst  (rst),
      .i_ra1(w_rs),
      .i_ra2(w_rt),
      .i_we (wb_we),
      .i_wa (wb_addr),
      .i_wd (wb_data),
      .o_rd1(w_rd1),
      .o_rd2(w_rd2)
   );

   // ID/EX register: reset, flush, hold, load or bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_rd1   <= '0;
         r_rd2   <= '0;
         r_imm   <= '0;
         r_jt    <= '0;
         r_pc    <= '0;
         r_rs    <= '0;
         r_rt    <= '0;
         r_dest  <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
      end else if (!r_valid || ex_ready) begin
         if (if_valid && !w_hazard) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_ctrl;
            r_rd1   <= w_rd1;
            r_rd2   <= w_rd2;
            r_imm   <= w_imm;
            r_jt    <= if_inst[25:0];
            r_pc    <= if_pc;
            r_rs    <= w_rs;
            r_rt    <= w_rt;
            r_dest  <= w_dest;
         end else begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
         end
      end
   end

   assign ex_valid    = r_valid;
   assign ex_rd1      = r_rd1;
   assign ex_rd2      = r_rd2;
   assign ex_imm      = r_imm;
   assign ex_jtarget  = r_jt;
   assign ex_pc       = r_pc;
   assign ex_rs       = r_rs;
   assign ex_rt       = r_rt;
   assign ex_dest     = r_dest;
   assign ex_regwrite = r_ctrl.regwrite;
   assign ex_alusrc   = r_ctrl.alusrc;
   assign ex_memtoreg = r_ctrl.memtoreg;
   assign ex_memread  = r_ctrl.memread;
   assign ex_memwrite = r_ctrl.memwrite;
   assign ex_branch   = r_ctrl.branch;
   assign ex_jump     = r_ctrl.jump;
   assign ex_lui      = r_ctrl.lui;
   assign ex_illegal  = r_ctrl.illegal;
   assign ex_aluctrl  = r_ctrl.aluctrl;

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised MIPS-subset instruction-decode stage with an integrated ID/EX pipeline register, register file and load-use hazard detection.
- Sits between the fetch stage and the execute stage.
- Adds valid/ready handshaking, stall, flush, write-through register bypass and illegal-opcode flagging to the plain decode stage.
- Output is registered: one-cycle latency from accept to ex_valid.

Parameters:
- XLEN, 32, datapath width of register data, PC and sign-extended immediate (≥32).
- REG_AW, 5, register address width; register count is 2**REG_AW. Instruction fields rs/rt/rd use the low REG_AW bits.
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_valid  in  1  fetch presents an instruction
- if_inst  in  32  instruction word
- if_pc  in  XLEN  PC+4 of the instruction
- id_ready  out  1  stage accepts if_inst this cycle
- flush  in  1  kill the instruction being decoded and the ID/EX contents
- wb_we  in  1  writeback enable
- wb_addr  in  REG_AW  writeback register
- wb_data  in  XLEN  writeback data
- ex_ready  in  1  execute stage accepts ID/EX contents
- ex_valid  out  1  ID/EX register holds a live instruction
- ex_rd1, ex_rd2  out  XLEN  operand values
- ex_imm  out  XLEN  sign-extended imm16
- ex_jtarget  out  26  jump field
- ex_pc  out  XLEN  registered if_pc
- ex_rs, ex_rt, ex_dest  out  REG_AW  source and destination register numbers
- ex_regwrite, ex_alusrc, ex_memtoreg, ex_memread, ex_memwrite, ex_branch, ex_jump, ex_lui, ex_illegal  out  1 each  control bits
- ex_aluctrl  out  3  ALU operation

Behaviour:
- Decode:
  - op=0x00 R-type: funct 0x20 add→010, 0x22 sub→110, 0x24 and→000, 0x25 or→001, 0x2A slt→111. Sets regwrite; dest=rd.
  - 0x23 lw: alusrc, memread, memtoreg, regwrite, add; dest=rt.
  - 0x2B sw: alusrc, memwrite, add.
  - 0x04 beq: branch, sub.
  - 0x08 addi: alusrc, regwrite, add; dest=rt.
  - 0x02 j: jump.
  - 0x0F lui: lui, alusrc, regwrite; dest=rt.
  - Any other op, or an unknown R-type funct: ex_illegal=1 with all other control bits 0.
- uses_rt = R-type | sw | beq. uses_rs = every opcode except j and lui.
- Hazard = ex_valid & ex_memread & ex_dest≠0 & ((uses_rs & rs==ex_dest) | (uses_rt & rt==ex_dest)).
- id_ready = ~rst & (flush | ((~ex_valid | ex_ready) & ~hazard)).
- Register file: synchronous write at posedge when wb_we and (wb_addr≠0 or ZERO_REG=0). Combinational read.
- Same-cycle bypass: if wb_we and wb_addr equals the read address (and that address is not the zero register), the read returns wb_data.
- ID/EX update, priority order at each posedge:
  1. rst: ex_valid=0, all ex_* outputs 0, all registers cleared to 0.
  2. flush: ex_valid=0, control bits 0. Any if_valid instruction is consumed and dropped.
  3. ex_valid & ~ex_ready: hold all ex_* outputs unchanged.
  4. if_valid & ~hazard: load the decoded fields; ex_valid=1.
  5. Otherwise, bubble: ex_valid=0, control bits 0. Data fields are don't-care.
- A held instruction never changes while stalled, even if wb writes its source register. Execute-side forwarding covers that case.
- A load-use stall lasts exactly one cycle once ex_ready=1.
- Reset asserted mid-stall takes priority; id_ready=0 during reset.

Decomposition:
- Package id_pkg holds:
  - opcode and funct constants;
  - ALU control encodings;
  - a packed control-bundle struct (regwrite…illegal, aluctrl) shared with the execute stage.
- One sub-module, id_regfile, parametrised by XLEN/REG_AW/ZERO_REG. It owns the write port, the two read ports and the bypass logic.

Test Plan:
- Reset, then if_valid with inst 0x2009_0005 (addi $9,$0,5) and ex_ready=1 → next cycle ex_valid=1, ex_imm=5, ex_dest=9, ex_alusrc=1, ex_regwrite=1, ex_aluctrl=010.
- wb_we=1, wb_addr=8, wb_data=0x1234 in the same cycle as decoding add $10,$8,$0 (0x0100_5020) → ex_rd1=0x1234 (bypass).
- lw $8,0($9) (0x8D28_0000), then add $10,$8,$9 (0x0109_5020) → id_ready=0 for one cycle, one bubble (ex_valid=0), then the add loads.
- ex_ready=0 for 3 cycles with ex_valid=1 → ex_* stable, id_ready=0. Release → the next instruction loads.
- flush=1 with if_valid=1 → next cycle ex_valid=0, id_ready=1 during the flush.
- Inst 0xFC00_0000 → ex_illegal=1, ex_regwrite=0. wb_we to register 0 with data 0xFFFF_FFFF → register 0 still reads 0.
